uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter in uart_top between N independent byte-stream requesters.
- Uses a round-robin grant with optional packet lock.
- Sits between client blocks and uart_top's tx_data/tx_start/tx_busy ports.
- Sequences one tx_start pulse per byte, then waits for tx_busy to rise and fall before the next grant. A start timeout guards against a transmitter that never goes busy.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 16: maximum bytes one requester may send under lock before forced release, 1..255.
- START_TIMEOUT, 64: cycles allowed from tx_start until tx_busy rises, 2..1023.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the last of a packet; ends the lock
- req_ready  out  NUM_REQ  one-hot; byte of requester i accepted this cycle
- tx_data  out  8  to uart_top tx_data
- tx_start  out  1  to uart_top tx_start, one-cycle pulse
- tx_busy  in  1  from uart_top tx_busy
- grant_id  out  clog2(NUM_REQ)  requester owning the current/last byte
- grant_active  out  1  high while a byte is between acceptance and tx_busy fall
- timeout_err  out  1  one-cycle pulse when START_TIMEOUT expires

Behaviour:
- Reset values: req_ready=0, tx_data=0, tx_start=0, grant_id=0, grant_active=0, timeout_err=0. Also state=IDLE, lock cleared, burst count=0, and the RR pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation aborts the current byte immediately. The arbiter ignores tx_busy until it is back in IDLE.
- IDLE:
  - Selection requires tx_busy=0.
  - If lock is set, only the lock owner is eligible.
  - Otherwise the winner is the first i with req_valid[i]=1, searching from pointer+1 upward with wrap.
  - On selection in cycle T: req_ready[sel]=1 (combinational, that cycle only); tx_data<=req_data[sel]; grant_id<=sel; pointer<=sel; grant_active<=1; go to START.
  - With no eligible request, stay in IDLE and keep all outputs stable.
- START: tx_start=1 for exactly one cycle (T+1); clear the timer; go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1, go to SENDING.
  - Otherwise increment the timer. When timer == START_TIMEOUT-1, pulse timeout_err, clear the lock and burst count, set grant_active=0, and go to IDLE.
  - The timed-out byte is dropped, not retried.
- SENDING: when tx_busy=0, set grant_active=0 and go to IDLE. The next acceptance can occur in that same cycle's successor.
- tx_data holds its value from T+1 until the next acceptance.
- Lock rules, evaluated at acceptance:
  - req_last=1: lock cleared, burst count=0.
  - req_last=0: lock set to sel; burst count incremented.
  - If the incremented count reaches MAX_BURST, the lock is cleared and the count reset. The pointer already points at the owner, so others get priority.
- A lock owner with req_valid=0 stalls everyone while locked. This is intended: packets are not interleaved.
- Simultaneous events:
  - Multiple valid requesters resolve by the pointer only.
  - req_valid dropping in the acceptance cycle is illegal. A requester holds valid/data until it sees ready.
- At most one byte is in flight. Throughput is one byte per tx_busy period plus 3 cycles.

Decomposition:
- Shared package uart_pkg:
  - arbiter state enum (IDLE, START, WAIT_BUSY, SENDING);
  - GRANT_W = clog2(NUM_REQ) helper;
  - TIMER_W constant.
- One sub-module, uart_rr_pick: combinational rotate-priority picker. Inputs are the request vector and pointer; outputs are sel and any_valid. It is reused later for the RX-side dispatcher.

Test Plan:
- Single request: req_valid[2]=1, data 0x5A, tx_busy model rises 2 cycles after start and holds 20 cycles -> req_ready[2] at T, tx_start at T+1, tx_data=0x5A, grant_active falls when busy falls.
- Round robin: all four valid continuously, last=1 on every byte -> grant_id sequence 0,1,2,3,0,1 with exactly one tx_start per byte.
- Packet lock: req1 sends 3 bytes (last on third) while req0 and req3 are valid -> grant 1,1,1 then 3,0. Repeat with MAX_BURST=2 -> grant 1,1 then 3.
- Timeout: tx_busy tied 0, START_TIMEOUT=8 -> timeout_err pulses 8 cycles after tx_start, state returns to IDLE, the next requester is granted.
- Reset in SENDING: assert rst for 1 cycle with tx_busy=1 -> all outputs 0 next cycle; no new grant until tx_busy=0; requester 0 wins first.
- Busy at start: tx_busy=1 from an external source while req0 is valid -> no req_ready until tx_busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Purpose: shared types and constants for the UART arbitration blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Arbiter sequencing states for one byte in flight.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    SENDING   = 2'd3
  } arb_state_t;

  // Wide enough for START_TIMEOUT up to 1023.
  localparam int TIMER_W = 10;

  // Width of a requester index; never below one bit.
  function automatic int grant_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
`timescale 1ns/1ps
// Purpose: rotate-priority picker, first set request above ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module uart_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         any_valid
);

  logic [W-1:0] idx;

  // Scan from the farthest slot down to ptr+1 so the closest hit is written last.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        sel       = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Purpose: round-robin share of one UART transmitter among NUM_REQ byte streams, with packet lock.
// Latency: byte accepted in cycle T, tx_start pulses at T+1; next grant after tx_busy falls.
// Backpressure: req_ready is held low while a byte is in flight or tx_busy is high.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [8*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic [grant_w(NUM_REQ)-1:0]  grant_id,
  output logic                         grant_active,
  output logic                         timeout_err
);

  localparam int                 GW         = grant_w(NUM_REQ);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [7:0]         BURST_MAX  = 8'(MAX_BURST);

  arb_state_t         state;
  logic [GW-1:0]      ptr;
  logic [GW-1:0]      lock_id;
  logic [GW-1:0]      sel;
  logic               lock_vld;
  logic               any_valid;
  logic               accept;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic [7:0]         burst_cnt;
  logic [7:0]         burst_nxt;
  logic [TIMER_W-1:0] timer;
  logic [NUM_REQ-1:0] elig;

  // While a packet is locked only its owner competes, so packets never interleave.
  always_comb begin
    elig = req_valid;
    if (lock_vld) begin
      elig          = '0;
      elig[lock_id] = req_valid[lock_id];
    end
  end

  uart_rr_pick #(
    .N (NUM_REQ),
    .W (GW)
  ) u_pick (
    .req       (elig),
    .ptr       (ptr),
    .sel       (sel),
    .any_valid (any_valid)
  );

  // Acceptance handshake and selected-byte mux; reset suppresses a same-cycle accept.
  always_comb begin
    accept    = (state == IDLE) && !tx_busy && any_valid && !rst;
    req_ready = '0;
    if (accept) req_ready[sel] = 1'b1;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == GW'(i)) sel_data = req_data[8*i +: 8];
    end
    sel_last  = req_last[sel];
    burst_nxt = burst_cnt + 8'd1;
  end

  // Byte sequencer: accept, pulse start, wait for busy rise (with timeout), wait for busy fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= GW'(NUM_REQ - 1);
      lock_vld     <= 1'b0;
      lock_id      <= '0;
      burst_cnt    <= '0;
      timer        <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data      <= sel_data;
            grant_id     <= sel;
            ptr          <= sel;
            grant_active <= 1'b1;
            tx_start     <= 1'b1;
            state        <= START;
            // Packet end or burst cap both release; ptr already sits on the owner.
            if (sel_last || (burst_nxt == BURST_MAX)) begin
              lock_vld  <= 1'b0;
              burst_cnt <= '0;
            end else begin
              lock_vld  <= 1'b1;
              lock_id   <= sel;
              burst_cnt <= burst_nxt;
            end
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= SENDING;
          end else if (timer == TIMER_LAST) begin
            // Transmitter never started: drop the byte and free the arbiter.
            timeout_err  <= 1'b1;
            lock_vld     <= 1'b0;
            burst_cnt    <= '0;
            grant_active <= 1'b0;
            state        <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SENDING: begin
          if (!tx_busy) begin
            grant_active <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
